// File: rtl/instr_pkg.sv
// instr_pkg: shared field layout, class/opcode/sys codes, FSM state type and encode/legality helpers.
// Revision: 1.0
`default_nettype none

package instr_pkg;

  localparam logic [1:0] CLS_DIMM = 2'b00;
  localparam logic [1:0] CLS_DREG = 2'b01;
  localparam logic [1:0] CLS_LS   = 2'b10;
  localparam logic [1:0] CLS_SYS  = 2'b11;

  localparam logic [4:0] OP_MOV = 5'b00000;
  localparam logic [4:0] OP_ADD = 5'b10001;
  localparam logic [4:0] OP_SUB = 5'b10010;
  localparam logic [4:0] OP_AND = 5'b10011;
  localparam logic [4:0] OP_OR  = 5'b10100;
  localparam logic [4:0] OP_XOR = 5'b10101;
  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_ST  = 5'b00001;

  localparam logic [3:0] SYS_B    = 4'b0000;
  localparam logic [3:0] SYS_BC   = 4'b0001;
  localparam logic [3:0] SYS_BR   = 4'b0010;
  localparam logic [3:0] SYS_NOP  = 4'b0100;
  localparam logic [3:0] SYS_HALT = 4'b1000;

  localparam int CLS_LSB  = 30;
  localparam int OP_LSB   = 25;
  localparam int RD_LSB   = 22;
  localparam int RS1_LSB  = 19;
  localparam int RS2_LSB  = 16;
  localparam int COND_LSB = 21;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

  // Fields a class does not use stay zero so words are canonical.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  cls,
    input logic [4:0]  op,
    input logic [2:0]  rd,
    input logic [2:0]  rs1,
    input logic [2:0]  rs2,
    input logic [3:0]  cond,
    input logic [15:0] imm
  );
    logic [31:0] w;
    w = 32'd0;
    w[CLS_LSB +: 2] = cls;
    case (cls)
      CLS_DIMM: begin
        w[OP_LSB +: 5]   = op;
        w[RD_LSB +: 3]   = rd;
        w[RS1_LSB +: 3]  = rs1;
        w[IMM_LSB +: 16] = imm;
      end
      CLS_DREG: begin
        w[OP_LSB +: 5]  = op;
        w[RD_LSB +: 3]  = rd;
        w[RS1_LSB +: 3] = rs1;
        w[RS2_LSB +: 3] = rs2;
      end
      CLS_LS: begin
        w[OP_LSB]        = op[0];
        w[RD_LSB +: 3]   = rd;
        w[RS1_LSB +: 3]  = rs1;
        w[IMM_LSB +: 16] = imm;
      end
      default: begin
        w[OP_LSB +: 4] = op[3:0];
        case (op[3:0])
          SYS_B:  w[IMM_LSB +: 16] = imm;
          SYS_BC: begin
            w[COND_LSB +: 4] = cond;
            w[IMM_LSB +: 16] = imm;
          end
          SYS_BR: begin
            w[RS1_LSB +: 3]  = rs1;
            w[IMM_LSB +: 16] = imm;
          end
          default: ;
        endcase
      end
    endcase
    return w;
  endfunction

  function automatic logic is_halt(input logic [1:0] cls, input logic [4:0] op);
    return (cls == CLS_SYS) && (op[3:0] == SYS_HALT);
  endfunction

  function automatic logic is_legal(input logic [1:0] cls, input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    case (cls)
      CLS_DIMM: ok = (op <= 5'b00101) ||
                     (op >= 5'b10001 && op <= 5'b10101) ||
                     (op >= 5'b11001 && op <= 5'b11101);
      CLS_DREG: ok = (op >= 5'b10001 && op <= 5'b10110) ||
                     (op >= 5'b11001 && op <= 5'b11101);
      CLS_LS:   ok = 1'b1;
      default:  ok = !op[4] && (op[3:0] == SYS_B  || op[3:0] == SYS_BC ||
                                op[3:0] == SYS_BR || op[3:0] == SYS_NOP ||
                                op[3:0] == SYS_HALT);
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/enc_fifo.sv
// enc_fifo: synchronous FIFO for encoded words; wrap-bit pointers distinguish full from empty.
// Revision: 1.0
`default_nettype none

module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wptr;
  logic [PW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign rdata = mem[rptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// instr_encoder: encodes field tuples into 32-bit words and streams them into IMEM.
// Revision: 1.0 -- optional ENC_LEGALITY_CHECK_EN rejects illegal tuples with an illegal pulse.
`default_nettype none

module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_cls,
  input  logic [4:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic [3:0]        in_cond,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              illegal
);

  enc_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_head;
  logic              accept;
  logic              legal;
  logic              push;
  logic              halt_acc;
  logic              write;
  logic              wrap;

  assign in_ready = (state == ST_LOAD) && !fifo_full;
  assign accept   = in_valid && in_ready;

`ifdef ENC_LEGALITY_CHECK_EN
  logic illegal_q;
  assign legal   = is_legal(in_cls, in_op);
  assign illegal = illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= accept && !legal;
  end
`else
  assign legal   = 1'b1;
  assign illegal = 1'b0;
`endif

  assign push     = accept && legal;
  assign halt_acc = push && is_halt(in_cls, in_op);
  assign write    = !fifo_empty && imem_ready;
  assign wrap     = write && (addr == '1);

  assign imem_we    = !fifo_empty;
  assign imem_addr  = addr;
  assign imem_wdata = fifo_empty ? 32'd0 : fifo_head;
  assign busy       = (state == ST_LOAD) || (state == ST_DRAIN);

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (encode_word(in_cls, in_op, in_rd, in_rs1, in_rs2, in_cond, in_imm)),
    .pop   (write),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      addr     <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Buffered words keep writing after a wrap, at addresses from 0 upward.
      if (write) begin
        addr <= addr + 1'b1;
        if (wrap) overflow <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr  <= base_addr;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (halt_acc || wrap) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            addr     <= base_addr;
            done     <= 1'b0;
            overflow <= 1'b0;
            state    <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
